// File: rtl/insfetch.sv
`default_nettype none
// ============================================================================
// insfetch : instruction prefetch queue, 32-bit fetch split into 16-bit words
// Revision : 1.0
// ============================================================================
module insfetch #(
    parameter int ADDR_W = 24,
    parameter int QWORDS = 8
) (
    input  logic              clk_0,
    input  logic              reset_n,
    input  logic              go,
    input  logic              romold,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              insrdy,
    output logic [15:0]       instruction,
    output logic [ADDR_W-1:0] ins_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_valid,
    input  logic [31:0]       mem_data
);

    localparam int C_PW = $clog2(QWORDS);
    localparam int C_CW = $clog2(QWORDS + 1);
    localparam logic [C_CW-1:0] C_LIMIT = C_CW'(QWORDS - 2);
    localparam logic [C_PW-1:0] C_LAST  = C_PW'(QWORDS - 1);

    logic [15:0]       r_q [QWORDS];
    logic [C_PW-1:0]   r_rd;
    logic [C_PW-1:0]   r_wr;
    logic [C_CW-1:0]   r_count;
    logic [ADDR_W-1:0] r_fetch;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_pc;
    logic              r_out;
    logic              r_stale;
    logic              r_skip;
    logic              r_req;

    logic              w_pop;
    logic              w_push;
    logic              w_two;
    logic              w_one;
    logic              w_out_after;
    logic              w_raise;
    logic [C_CW-1:0]   w_count_next;
    logic [ADDR_W-1:0] w_base;
    logic              w_unused;

    function automatic logic [C_PW-1:0] f_inc(input logic [C_PW-1:0] p);
        return (p == C_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_unused = jump_addr[0];

    assign insrdy      = (r_count != '0);
    assign instruction = r_q[r_rd];
    assign ins_pc      = r_pc;
    assign mem_req     = r_req;
    assign mem_addr    = r_mem_addr;

    always_comb begin
        w_pop       = romold & insrdy & ~jump;
        w_push      = mem_valid & r_out & ~r_stale & ~jump;
        w_two       = w_push & ~r_skip;
        w_one       = w_push & r_skip;
        // a read whose data returns this cycle no longer blocks the next one
        w_out_after = r_out & ~mem_valid;
        w_base      = jump ? {jump_addr[ADDR_W-1:2], 2'b00} : r_fetch;

        w_count_next = r_count;
        if (jump) begin
            w_count_next = '0;
        end else begin
            if (w_two) begin
                w_count_next = w_count_next + C_CW'(2);
            end else if (w_one) begin
                w_count_next = w_count_next + C_CW'(1);
            end
            if (w_pop) begin
                w_count_next = w_count_next - C_CW'(1);
            end
        end

        w_raise = ~r_req & go & ~w_out_after & (w_count_next <= C_LIMIT);
    end

    always_ff @(posedge clk_0 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < QWORDS; i++) begin
                r_q[i] <= '0;
            end
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
            r_fetch    <= '0;
            r_mem_addr <= '0;
            r_pc       <= '0;
            r_out      <= 1'b0;
            r_stale    <= 1'b0;
            r_skip     <= 1'b0;
            r_req      <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_req   <= (r_req & ~mem_ack) | w_raise;
            r_out   <= w_out_after | w_raise;

            // fetch pointer moves at issue so a stale ack cannot disturb a redirect
            if (w_raise) begin
                r_mem_addr <= w_base;
                r_fetch    <= w_base + ADDR_W'(4);
            end else if (jump) begin
                r_fetch <= w_base;
            end

            if (jump) begin
                r_stale <= w_out_after;
                r_skip  <= jump_addr[1];
                r_pc    <= {jump_addr[ADDR_W-1:1], 1'b0};
                r_rd    <= '0;
                r_wr    <= '0;
            end else begin
                if (mem_valid) begin
                    r_stale <= 1'b0;
                end
                if (w_push) begin
                    r_skip <= 1'b0;
                end
                if (w_pop) begin
                    r_pc <= r_pc + ADDR_W'(2);
                    r_rd <= f_inc(r_rd);
                end
                if (w_two) begin
                    r_q[r_wr]        <= mem_data[31:16];
                    r_q[f_inc(r_wr)] <= mem_data[15:0];
                    r_wr             <= f_inc(f_inc(r_wr));
                end else if (w_one) begin
                    r_q[r_wr] <= mem_data[15:0];
                    r_wr      <= f_inc(r_wr);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_insfetch.sv
`default_nettype none
// ============================================================================
// tb_insfetch : randomized bench for insfetch against an ideal word-stream model
// Revision    : 1.0
// ============================================================================
module tb_insfetch;

    localparam int AW = 24;

    logic          clk_0;
    logic          reset_n;
    logic          go;
    logic          romold;
    logic          jump;
    logic [AW-1:0] jump_addr;
    logic          insrdy;
    logic [15:0]   instruction;
    logic [AW-1:0] ins_pc;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic          mem_valid;
    logic [31:0]   mem_data;

    insfetch #(.ADDR_W(AW), .QWORDS(8)) dut (
        .clk_0(clk_0), .reset_n(reset_n), .go(go), .romold(romold),
        .jump(jump), .jump_addr(jump_addr), .insrdy(insrdy),
        .instruction(instruction), .ins_pc(ins_pc), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_valid(mem_valid),
        .mem_data(mem_data)
    );

    int n_total = 0;
    int n_bad   = 0;

    // memory responder state
    int            ack_pct = 100;
    int            dlo = 1;
    int            dhi = 1;
    logic          ret_busy = 1'b0;
    int            ret_cnt = 0;
    logic [AW-1:0] ret_addr = '0;

    // reference model and protocol history
    logic [AW-1:0] model_pc = '0;
    logic          req_hold = 1'b0;
    logic [AW-1:0] hold_addr = '0;
    logic          prev_req = 1'b0;
    logic          prev_go = 1'b0;
    logic [AW-1:0] acks[$];
    logic [15:0]   pops[$];

    initial begin
        clk_0 = 1'b0;
        forever #5 clk_0 = ~clk_0;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memf(input logic [AW-1:0] a);
        case (a)
            24'h000000: return 32'h11112222;
            24'h000004: return 32'h33334444;
            24'h000100: return 32'hAAAABBBB;
            default:    return {a[15:0] ^ 16'hC3A5, a[23:8] ^ 16'h5A0F};
        endcase
    endfunction

    // big-endian word at any even byte address of the program image
    function automatic logic [15:0] word_at(input logic [AW-1:0] p);
        logic [31:0] d;
        d = memf({p[AW-1:2], 2'b00});
        return p[1] ? d[15:0] : d[31:16];
    endfunction

    // one clock cycle: entered just after a falling edge with inputs already set
    task automatic tick();
        mem_valid = 1'b0;
        if (ret_busy) begin
            if (ret_cnt == 0) begin
                mem_valid = 1'b1;
                mem_data  = memf(ret_addr);
                ret_busy  = 1'b0;
            end else begin
                ret_cnt--;
            end
        end
        if (req_hold) begin
            chk("req_held", 32'(mem_req), 32'd1);
            chk("addr_held", 32'(mem_addr), 32'(hold_addr));
        end
        if (mem_req && !prev_req) chk("go_gate", 32'(prev_go), 32'd1);
        mem_ack = mem_req && ($urandom_range(99) < 32'(ack_pct));
        if (mem_ack) begin
            chk("one_outstanding", 32'(ret_busy), 32'd0);
            chk("addr_align", 32'(mem_addr[1:0]), 32'd0);
            acks.push_back(mem_addr);
            ret_busy = 1'b1;
            ret_addr = mem_addr;
            ret_cnt  = int'($urandom_range(dhi - 1, dlo - 1));
        end
        if (jump) begin
            model_pc = {jump_addr[AW-1:1], 1'b0};
        end else if (romold && insrdy) begin
            chk("ins", 32'(instruction), 32'(word_at(model_pc)));
            chk("ins_pc", 32'(ins_pc), 32'(model_pc));
            pops.push_back(instruction);
            model_pc = model_pc + AW'(2);
        end
        req_hold  = mem_req && !mem_ack;
        hold_addr = mem_addr;
        prev_req  = mem_req;
        prev_go   = go;
        @(negedge clk_0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        mem_ack   = 1'b0;
        mem_valid = 1'b0;
        mem_data  = '0;
        jump      = 1'b0;
        ret_busy  = 1'b0;
        model_pc  = '0;
        req_hold  = 1'b0;
        prev_req  = 1'b0;
        acks.delete();
        pops.delete();
        @(negedge clk_0);
        @(negedge clk_0);
        chk("rst_insrdy", 32'(insrdy), 32'd0);
        chk("rst_instruction", 32'(instruction), 32'd0);
        chk("rst_ins_pc", 32'(ins_pc), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset_n = 1'b1;
        prev_go = go;
    endtask

    initial begin
        go = 1'b0; romold = 1'b0; jump = 1'b0; jump_addr = '0;
        mem_ack = 1'b0; mem_valid = 1'b0; mem_data = '0;
        reset_n = 1'b0;

        // basic stream with zero-wait memory
        do_reset();
        go = 1'b1; romold = 1'b1; ack_pct = 100; dlo = 1; dhi = 1;
        for (int i = 0; i < 50 && pops.size() < 4; i++) tick();
        chk("t1_pops", 32'(pops.size() >= 4), 32'd1);
        if (pops.size() >= 4) begin
            chk("t1_w0", 32'(pops[0]), 32'h1111);
            chk("t1_w1", 32'(pops[1]), 32'h2222);
            chk("t1_w2", 32'(pops[2]), 32'h3333);
            chk("t1_w3", 32'(pops[3]), 32'h4444);
        end

        // fill without consuming, then pop two
        do_reset();
        go = 1'b1; romold = 1'b0;
        ticks(20);
        chk("t2_reads", 32'(acks.size()), 32'd4);
        if (acks.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t2_addr", 32'(acks[i]), 32'(4 * i));
        end
        chk("t2_idle_req", 32'(mem_req), 32'd0);
        romold = 1'b1; ticks(2); romold = 1'b0;
        ticks(6);
        chk("t2_fifth", 32'(acks.size()), 32'd5);
        if (acks.size() == 5) chk("t2_fifth_addr", 32'(acks[4]), 32'h10);

        // jump to a half-long target; same-cycle romold is discarded
        jump = 1'b1; jump_addr = 24'h000102; romold = 1'b1;
        tick();
        jump = 1'b0; romold = 1'b0;
        chk("t3_req", 32'(mem_req), 32'd1);
        chk("t3_addr", 32'(mem_addr), 32'h100);
        pops.delete();
        romold = 1'b1;
        for (int i = 0; i < 50 && pops.size() < 2; i++) tick();
        romold = 1'b0;
        chk("t3_pops", 32'(pops.size() >= 2), 32'd1);
        if (pops.size() >= 2) begin
            chk("t3_first", 32'(pops[0]), 32'hBBBB);
            chk("t3_second", 32'(pops[1]), 32'(word_at(24'h104)));
        end

        // jump while the read at 0x10 is outstanding
        do_reset();
        go = 1'b1; romold = 1'b0;
        ticks(20);
        dlo = 6; dhi = 6;
        romold = 1'b1; ticks(2); romold = 1'b0;
        for (int i = 0; i < 20 && !(ret_busy && ret_addr == 24'h10); i++) tick();
        chk("t4_outstanding", 32'(ret_busy && ret_addr == 24'h10), 32'd1);
        jump = 1'b1; jump_addr = 24'h000200;
        tick();
        jump = 1'b0;
        acks.delete(); pops.delete();
        dlo = 1; dhi = 1; romold = 1'b1;
        for (int i = 0; i < 60 && pops.size() < 4; i++) tick();
        romold = 1'b0;
        chk("t4_pops", 32'(pops.size() >= 4), 32'd1);
        if (acks.size() > 0) chk("t4_new_addr", 32'(acks[0]), 32'h200);
        if (pops.size() > 0) chk("t4_first", 32'(pops[0]), 32'(word_at(24'h200)));

        // push and pop in the same cycle at six queued words
        do_reset();
        go = 1'b1; romold = 1'b0; dlo = 3; dhi = 3;
        for (int i = 0; i < 60 && acks.size() < 4; i++) tick();
        for (int i = 0; i < 10 && !(ret_busy && ret_cnt == 0); i++) tick();
        chk("t5_sync", 32'(ret_busy && ret_cnt == 0), 32'd1);
        romold = 1'b1; tick(); romold = 1'b0;
        ticks(10);
        chk("t5_no_extra_req", 32'(acks.size()), 32'd4);
        chk("t5_insrdy", 32'(insrdy), 32'd1);
        romold = 1'b1; tick(); romold = 1'b0;
        for (int i = 0; i < 10 && acks.size() < 5; i++) tick();
        chk("t5_refill", 32'(acks.size()), 32'd5);
        go = 1'b0;
        for (int i = 0; i < 10 && ret_busy; i++) tick();
        tick();
        romold = 1'b1; ticks(12); romold = 1'b0;
        chk("t5_total_words", 32'(pops.size()), 32'd10);
        chk("t5_empty", 32'(insrdy), 32'd0);
        chk("t5_no_read_go_low", 32'(acks.size()), 32'd5);

        // randomized traffic
        do_reset();
        ack_pct = 70; dlo = 1; dhi = 4;
        for (int i = 0; i < 3000; i++) begin
            go        = ($urandom_range(7) != 0);
            romold    = ($urandom_range(2) != 0);
            jump      = ($urandom_range(39) == 0);
            jump_addr = AW'($urandom);
            tick();
        end
        jump = 1'b0; go = 1'b1;

        // asynchronous reset with a request pending
        do_reset();
        ack_pct = 100; dlo = 1; dhi = 1; romold = 1'b1;
        ticks(8);
        romold = 1'b0; ack_pct = 0;
        for (int i = 0; i < 20 && !mem_req; i++) tick();
        chk("t6_req_before", 32'(mem_req), 32'd1);
        #2;
        reset_n = 1'b0; mem_ack = 1'b0; mem_valid = 1'b0;
        #1;
        chk("t6_req", 32'(mem_req), 32'd0);
        chk("t6_insrdy", 32'(insrdy), 32'd0);
        chk("t6_ins_pc", 32'(ins_pc), 32'd0);
        ret_busy = 1'b0; model_pc = '0; req_hold = 1'b0; prev_req = 1'b0;
        acks.delete(); pops.delete();
        @(negedge clk_0);
        reset_n = 1'b1; prev_go = go;
        ack_pct = 100; romold = 1'b1;
        for (int i = 0; i < 30 && pops.size() < 4; i++) tick();
        chk("t6_restart_pops", 32'(pops.size() >= 4), 32'd1);
        if (acks.size() > 0) chk("t6_restart_addr", 32'(acks[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
